// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM/WB stage signal bundle.
// master = memory-stage side (drives slot inputs, observes writeback);
// slave  = the MEM/WB stage itself.
interface mem_wb_stage_if #(
   parameter int unsigned WORD_LENGTH    = 8,
   parameter int unsigned REG_ADDR_WIDTH = 3
);
   logic                      stall;
   logic                      flush;
   logic                      inValid;
   logic                      inRegWrite;
   logic                      inMemToReg;
   logic                      inHalt;
   logic [REG_ADDR_WIDTH-1:0] inDestReg;
   logic [WORD_LENGTH-1:0]    inAluResult;
   logic [WORD_LENGTH-1:0]    inMemData;
   logic                      regFileWrite;
   logic [REG_ADDR_WIDTH-1:0] regFileWriteAddr;
   logic [WORD_LENGTH-1:0]    regFileWriteData;
   logic                      halted;
   logic [15:0]               retireCount;

   modport master (
      output stall, flush, inValid, inRegWrite, inMemToReg, inHalt,
             inDestReg, inAluResult, inMemData,
      input  regFileWrite, regFileWriteAddr, regFileWriteData, halted, retireCount
   );

   modport slave (
      input  stall, flush, inValid, inRegWrite, inMemToReg, inHalt,
             inDestReg, inAluResult, inMemData,
      output regFileWrite, regFileWriteAddr, regFileWriteData, halted, retireCount
   );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback for the 8-bit core.
// The register-file write port doubles as the execute-stage forwarding source.
// Optional feature macro: WB_RETIRE_COUNT_EN (16-bit saturating retired-write
// counter); when undefined, retireCount is tied to zero.
module mem_wb_stage #(
   parameter int unsigned WORD_LENGTH    = 8,
   parameter int unsigned REG_ADDR_WIDTH = 3,
   parameter bit          R0_HARDWIRED   = 1'b1
) (
   input logic           clk,
   input logic           rst,
   mem_wb_stage_if.slave wbBus
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } stateT;

   stateT                     state;
   stateT                     stateNext;

   logic                      validQ;
   logic                      regWriteQ;
   logic                      memToRegQ;
   logic                      haltQ;
   logic [REG_ADDR_WIDTH-1:0] destRegQ;
   logic [WORD_LENGTH-1:0]    aluResultQ;
   logic [WORD_LENGTH-1:0]    memDataQ;

   logic                      r0Blocked;
   logic                      writeEn;
   logic                      haltedOut;

   // Pipeline register: flush clears the slot, stall holds it, else load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         validQ     <= 1'b0;
         regWriteQ  <= 1'b0;
         memToRegQ  <= 1'b0;
         haltQ      <= 1'b0;
         destRegQ   <= '0;
         aluResultQ <= '0;
         memDataQ   <= '0;
      end else if (wbBus.flush) begin
         validQ     <= 1'b0;
         regWriteQ  <= 1'b0;
         memToRegQ  <= 1'b0;
         haltQ      <= 1'b0;
         destRegQ   <= '0;
         aluResultQ <= '0;
         memDataQ   <= '0;
      end else if (!wbBus.stall) begin
         validQ     <= wbBus.inValid;
         regWriteQ  <= wbBus.inRegWrite;
         memToRegQ  <= wbBus.inMemToReg;
         haltQ      <= wbBus.inHalt;
         destRegQ   <= wbBus.inDestReg;
         aluResultQ <= wbBus.inAluResult;
         memDataQ   <= wbBus.inMemData;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= stateNext;
      end
   end

   // FSM next state: a valid HALT leaving an unstalled WB slot stops the core for good.
   always_comb begin
      stateNext = state;
      case (state)
         RUN:     if (validQ && haltQ && !wbBus.stall) stateNext = HALTED;
         HALTED:  stateNext = HALTED;
         default: stateNext = RUN;
      endcase
   end

   assign r0Blocked = R0_HARDWIRED && (destRegQ == '0);

   // FSM outputs: write only in RUN, never for HALT, R0 (if hardwired) or a stalled slot.
   always_comb begin
      writeEn   = 1'b0;
      haltedOut = 1'b0;
      case (state)
         RUN:     writeEn = validQ && regWriteQ && !haltQ && !r0Blocked && !wbBus.stall;
         HALTED:  haltedOut = 1'b1;
         default: writeEn = 1'b0;
      endcase
   end

   assign wbBus.regFileWrite     = writeEn;
   assign wbBus.regFileWriteAddr = destRegQ;
   assign wbBus.regFileWriteData = memToRegQ ? memDataQ : aluResultQ;
   assign wbBus.halted           = haltedOut;

`ifdef WB_RETIRE_COUNT_EN
   logic [15:0] retireCountQ;

   // Retired-write counter, saturating at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retireCountQ <= '0;
      end else if (writeEn && (retireCountQ != '1)) begin
         retireCountQ <= retireCountQ + 16'd1;
      end
   end

   assign wbBus.retireCount = retireCountQ;
`else
   assign wbBus.retireCount = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed bench for mem_wb_stage with a slot-level reference
// model checked on every falling edge, plus literal spot checks.
module tb_mem_wb_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int nChecks = 0;
   int nErrors = 0;
   bit compareOn = 1'b0;

   mem_wb_stage_if #(.WORD_LENGTH(8), .REG_ADDR_WIDTH(3)) busIf ();

   mem_wb_stage #(
      .WORD_LENGTH(8),
      .REG_ADDR_WIDTH(3),
      .R0_HARDWIRED(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wbBus(busIf)
   );

   always #5 clk = ~clk;

   // Reference model: the instruction sitting in WB, whether the core has halted,
   // and how many register writes have retired.
   bit         mValid = 0, mRegWrite = 0, mMemToReg = 0, mHalt = 0;
   logic [2:0] mDest = '0;
   logic [7:0] mAlu = '0, mMem = '0;
   bit         mHalted = 0;
   logic [15:0] mCount = '0;

   function automatic bit modelWrite();
      bit isRealWrite = mValid && mRegWrite && !mHalt;
      bit toZeroReg   = (mDest == 3'd0);
      return isRealWrite && !toZeroReg && !mHalted && !busIf.stall;
   endfunction

   function automatic logic [15:0] modelCount();
`ifdef WB_RETIRE_COUNT_EN
      return mCount;
`else
      return 16'h0000;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mValid <= 0; mRegWrite <= 0; mMemToReg <= 0; mHalt <= 0;
         mDest <= '0; mAlu <= '0; mMem <= '0;
         mHalted <= 0; mCount <= '0;
      end else begin
         if (mValid && mHalt && !busIf.stall) mHalted <= 1;
         if (modelWrite() && mCount != 16'hFFFF) mCount <= mCount + 16'd1;
         if (busIf.flush) begin
            mValid <= 0; mRegWrite <= 0; mMemToReg <= 0; mHalt <= 0;
            mDest <= '0; mAlu <= '0; mMem <= '0;
         end else if (!busIf.stall) begin
            mValid <= busIf.inValid; mRegWrite <= busIf.inRegWrite;
            mMemToReg <= busIf.inMemToReg; mHalt <= busIf.inHalt;
            mDest <= busIf.inDestReg; mAlu <= busIf.inAluResult; mMem <= busIf.inMemData;
         end
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model comparison on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (compareOn) begin
            check("model.write", 16'(busIf.regFileWrite), 16'(modelWrite()));
            check("model.addr", 16'(busIf.regFileWriteAddr), 16'(mDest));
            check("model.data", 16'(busIf.regFileWriteData), 16'(mMemToReg ? mMem : mAlu));
            check("model.halted", 16'(busIf.halted), 16'(mHalted));
            check("model.count", busIf.retireCount, modelCount());
         end
      end
   end

   task automatic drv(input bit st, input bit fl, input bit v, input bit rw, input bit m2r,
                      input bit h, input logic [2:0] d, input logic [7:0] alu, input logic [7:0] mem);
      busIf.stall = st; busIf.flush = fl; busIf.inValid = v; busIf.inRegWrite = rw;
      busIf.inMemToReg = m2r; busIf.inHalt = h; busIf.inDestReg = d;
      busIf.inAluResult = alu; busIf.inMemData = mem;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resetPulse();
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      tick();
   endtask

   task automatic litWrite(input string name, input bit w, input logic [2:0] a, input logic [7:0] d);
      check({name, ".write"}, 16'(busIf.regFileWrite), 16'(w));
      if (w) begin
         check({name, ".addr"}, 16'(busIf.regFileWriteAddr), 16'(a));
         check({name, ".data"}, 16'(busIf.regFileWriteData), 16'(d));
      end
   endtask

   localparam logic [15:0] TEN = 16'd10;

   initial begin
      idle();
      repeat (2) tick();
      compareOn = 1'b1;
      #1;
      litWrite("rstHeld", 0, 3'd0, 8'h00);
      check("rstHeld.addr", 16'(busIf.regFileWriteAddr), 16'h0000);
      check("rstHeld.data", 16'(busIf.regFileWriteData), 16'h0000);
      check("rstHeld.halted", 16'(busIf.halted), 16'h0000);
      check("rstHeld.count", busIf.retireCount, 16'h0000);
      #1 rst = 1'b0;
      tick();

      // Reset mid-write discards the held slot at once.
      drv(0, 0, 1, 1, 0, 0, 3'd1, 8'hAB, 8'h00);
      tick();
      idle();
      #1 rst = 1'b1;
      #1;
      check("midRst.write", 16'(busIf.regFileWrite), 16'h0000);
      check("midRst.data", 16'(busIf.regFileWriteData), 16'h0000);
      #1 rst = 1'b0;
      tick();

      // ALU writeback.
      drv(0, 0, 1, 1, 0, 0, 3'd3, 8'h5A, 8'hEE);
      tick();
      idle(); #1;
      litWrite("alu", 1, 3'd3, 8'h5A);
      tick();

      // Load writeback, then a write to hardwired R0.
      drv(0, 0, 1, 1, 1, 0, 3'd5, 8'h11, 8'hC3);
      tick();
      drv(0, 0, 1, 1, 0, 0, 3'd0, 8'h77, 8'h00);
      #1;
      litWrite("load", 1, 3'd5, 8'hC3);
      tick();
      idle(); #1;
      litWrite("r0", 0, 3'd0, 8'h00);
      tick();

      // Stall for 3 cycles: no write, then exactly one write.
      drv(0, 0, 1, 1, 0, 0, 3'd6, 8'h42, 8'h00);
      tick();
      drv(1, 0, 1, 1, 0, 0, 3'd7, 8'h99, 8'h00);
      for (int i = 0; i < 3; i++) begin
         #1;
         litWrite("stallHold", 0, 3'd0, 8'h00);
         tick();
      end
      idle(); #1;
      litWrite("stallRelease", 1, 3'd6, 8'h42);
      tick();
      #1;
      litWrite("stallOnce", 0, 3'd0, 8'h00);
      tick();

      // Flush together with stall turns the slot into a bubble.
      drv(0, 0, 1, 1, 0, 0, 3'd2, 8'h33, 8'h00);
      tick();
      drv(1, 1, 1, 1, 0, 0, 3'd4, 8'h44, 8'h00);
      tick();
      idle(); #1;
      litWrite("flushStall", 0, 3'd0, 8'h00);
      check("flushStall.data", 16'(busIf.regFileWriteData), 16'h0000);
      tick();

      // Counter: 10 real writes plus 2 to R0.
      resetPulse();
      for (int i = 0; i < 12; i++) begin
         drv(0, 0, 1, 1, 0, 0, (i < 10) ? 3'(i % 7 + 1) : 3'd0, 8'(i), 8'h00);
         tick();
      end
      idle();
      tick();
      #1;
`ifdef WB_RETIRE_COUNT_EN
      check("count10", busIf.retireCount, TEN);
`else
      check("countTied", busIf.retireCount, 16'h0000);
`endif
      tick();

      // HALT with regWrite set retires without writing; later writes are frozen.
      drv(0, 0, 1, 1, 0, 1, 3'd4, 8'h55, 8'h00);
      tick();
      drv(0, 0, 1, 1, 0, 0, 3'd2, 8'h10, 8'h00);
      #1;
      litWrite("haltNoWrite", 0, 3'd0, 8'h00);
      check("haltPending", 16'(busIf.halted), 16'h0000);
      for (int i = 0; i < 4; i++) begin
         tick();
         drv(0, 0, 1, 1, 0, 0, 3'(i + 1), 8'(8'h20 + i), 8'h00);
         #1;
         check("halted", 16'(busIf.halted), 16'h0001);
         litWrite("haltedWrite", 0, 3'd0, 8'h00);
      end
      tick();
      idle(); #1;
      check("haltedLoads.data", 16'(busIf.regFileWriteData), 16'h0023);
`ifdef WB_RETIRE_COUNT_EN
      check("countFrozen", busIf.retireCount, TEN);
`endif
      resetPulse();
      #1;
      check("haltCleared", 16'(busIf.halted), 16'h0000);

`ifdef WB_RETIRE_COUNT_EN
      // Saturation: more writes than the counter can hold.
      drv(0, 0, 1, 1, 0, 0, 3'd1, 8'h01, 8'h00);
      for (int i = 0; i < 65540; i++) tick();
      idle();
      tick();
      #1;
      check("countSat", busIf.retireCount, 16'hFFFF);
`endif

      tick();
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
